// File: rtl/hc595_rx_pkg.sv
// rtl/hc595_rx_pkg.sv - shared widths and word-to-segment mapping for the 74HC595 receiver
package hc595_rx_pkg;

    localparam int SEL_W     = 6;
    localparam int SEG_W     = 8;
    localparam int WORD_W    = 14;
    localparam int BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = BIT_CNT_W'(WORD_W);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX  = '1;

    // Segment bits sit MSB-first at the top of the word: seg[k] = word[13-k].
    function automatic logic [SEG_W-1:0] word_to_seg(input logic [WORD_W-1:0] word);
        logic [SEG_W-1:0] seg_v;
        seg_v = '0;
        for (int k = 0; k < SEG_W; k++) begin
            seg_v[k] = word[WORD_W-1-k];
        end
        return seg_v;
    endfunction

endpackage

// File: rtl/hc595_rx_sync.sv
// rtl/hc595_rx_sync.sv - plain multi-flop synchronizer with selectable reset value
module hc595_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/hc595_rx_sync_rise.sv
// rtl/hc595_rx_sync_rise.sv - synchronizer followed by a registered one-cycle rising-edge pulse
module sync_rise #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic sync_s;
    logic prev_q;
    logic rise_q;

    hc595_rx_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (d_i),
        .q_o    (sync_s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sync_s;
            rise_q <= sync_s & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/hc595_rx.sv
// rtl/hc595_rx.sv - 74HC595 bus snooper latching sel/seg; HC595_RX_FRAME_CHK_EN enables bit-count checking
module hc595_rx
    import hc595_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             ds,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             oe,
    output logic [SEL_W-1:0] sel,
    output logic [SEG_W-1:0] seg,
    output logic             blank,
    output logic             data_valid,
    output logic             frame_err
);

    logic ds_s;
    logic oe_s;
    logic shcp_rise;
    logic stcp_rise;

    hc595_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ds_sync (
        .clk_i (sys_clk), .rst_ni (sys_rst_n), .d_i (ds), .q_o (ds_s)
    );

    hc595_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_oe_sync (
        .clk_i (sys_clk), .rst_ni (sys_rst_n), .d_i (oe), .q_o (oe_s)
    );

    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_shcp_rise (
        .clk_i (sys_clk), .rst_ni (sys_rst_n), .d_i (shcp), .rise_o (shcp_rise)
    );

    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_stcp_rise (
        .clk_i (sys_clk), .rst_ni (sys_rst_n), .d_i (stcp), .rise_o (stcp_rise)
    );

    // The rise pulses come out one flop after the sync chain, so ds gets the same extra flop.
    logic              ds_q;
    logic [WORD_W-1:0] sr_q,  sr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              blank_q;
    logic              dv_q,  dv_d;

`ifdef HC595_RX_FRAME_CHK_EN
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 fe_q, fe_d;
`endif

    always_comb begin
        sr_d  = sr_q;
        sel_d = sel_q;
        seg_d = seg_q;
        dv_d  = 1'b0;
        if (shcp_rise) begin
            sr_d = {ds_q, sr_q[WORD_W-1:1]};
        end
`ifdef HC595_RX_FRAME_CHK_EN
        fe_d      = 1'b0;
        bit_cnt_d = bit_cnt_q;
        if (stcp_rise) begin
            if (bit_cnt_q == BIT_CNT_FULL) begin
                sel_d = sr_q[SEL_W-1:0];
                seg_d = word_to_seg(sr_q);
                dv_d  = 1'b1;
            end else begin
                fe_d = 1'b1;
            end
            // A coincident shift belongs to the next frame.
            bit_cnt_d = shcp_rise ? BIT_CNT_W'(1) : '0;
        end else if (shcp_rise && (bit_cnt_q != BIT_CNT_MAX)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
`else
        if (stcp_rise) begin
            sel_d = sr_q[SEL_W-1:0];
            seg_d = word_to_seg(sr_q);
            dv_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ds_q    <= 1'b0;
            sr_q    <= '0;
            sel_q   <= '0;
            seg_q   <= '0;
            blank_q <= 1'b1;
            dv_q    <= 1'b0;
        end else begin
            ds_q    <= ds_s;
            sr_q    <= sr_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            blank_q <= oe_s;
            dv_q    <= dv_d;
        end
    end

`ifdef HC595_RX_FRAME_CHK_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt_q <= '0;
            fe_q      <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            fe_q      <= fe_d;
        end
    end

    assign frame_err = fe_q;
`else
    assign frame_err = 1'b0;
`endif

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign blank      = blank_q;
    assign data_valid = dv_q;

endmodule

// File: tb/tb_hc595_rx.sv
// tb/tb_hc595_rx.sv - directed table-driven bench for hc595_rx
module tb_hc595_rx;

    localparam int SYNC_STAGES = 2;
    localparam int LAT_LATCH   = SYNC_STAGES + 2;
    localparam int LAT_BLANK   = SYNC_STAGES + 1;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       ds, shcp, stcp, oe;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       blank, data_valid, frame_err;

    hc595_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .ds         (ds),
        .shcp       (shcp),
        .stcp       (stcp),
        .oe         (oe),
        .sel        (sel),
        .seg        (seg),
        .blank      (blank),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;

    always @(negedge sys_clk) begin
        if (data_valid) dv_cnt++;
        if (frame_err)  fe_cnt++;
    end

    typedef struct {
        logic [13:0] word;
        logic [5:0]  exp_sel;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge sys_clk) ds = b;
        @(negedge sys_clk) shcp = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk) shcp = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic send_bits(input logic [13:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(w[i]);
    endtask

    // Raises stcp (optionally with shcp on the same pin edge) and checks which pulse appears and when.
    task automatic do_latch(input logic expect_dv, input logic also_shift, input logic sbit,
                            input logic [5:0] es, input logic [7:0] eg, input string name);
        int dv_at;
        int fe_at;
        dv_at = 0;
        fe_at = 0;
        @(negedge sys_clk) ds = sbit;
        @(negedge sys_clk);
        stcp = 1'b1;
        if (also_shift) shcp = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge sys_clk);
            #1;
            if (data_valid) dv_at = (dv_at == 0) ? i : 99;
            if (frame_err)  fe_at = (fe_at == 0) ? i : 99;
            if (i == 2) begin
                stcp = 1'b0;
                shcp = 1'b0;
            end
        end
        check({name, "_dv_cycle"}, dv_at, expect_dv ? LAT_LATCH : 0);
        check({name, "_fe_cycle"}, fe_at, expect_dv ? 0 : LAT_LATCH);
        check({name, "_sel"}, sel, es);
        check({name, "_seg"}, seg, eg);
    endtask

    task automatic blank_step(input logic val, input string name);
        int at;
        logic [5:0] s0;
        logic [7:0] g0;
        at = 0;
        s0 = sel;
        g0 = seg;
        @(negedge sys_clk) oe = val;
        for (int i = 1; i <= 6; i++) begin
            @(posedge sys_clk);
            #1;
            if (blank == val && at == 0) at = i;
        end
        check({name, "_latency"}, at, LAT_BLANK);
        check({name, "_sel_hold"}, sel, s0);
        check({name, "_seg_hold"}, seg, g0);
    endtask

    initial begin
        int fe0;
        vecs[0] = '{14'h00C1, 6'h01, 8'hC0};
        vecs[1] = '{14'h1260, 6'h20, 8'h92};
        vecs[2] = '{14'h27C2, 6'h02, 8'hF9};
        vecs[3] = '{14'h3FFF, 6'h3F, 8'hFF};
        vecs[4] = '{14'h296A, 6'h2A, 8'hA5};
        vecs[5] = '{14'h2015, 6'h15, 8'h01};
        vecs[6] = '{14'h0000, 6'h00, 8'h00};

        sys_rst_n = 1'b0;
        ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_sel", sel, 6'h00);
        check("rst_seg", seg, 8'h00);
        check("rst_blank", blank, 1'b1);
        sys_rst_n = 1'b1;

        repeat (100) @(negedge sys_clk);
        check("idle_sel", sel, 6'h00);
        check("idle_seg", seg, 8'h00);
        check("idle_blank", blank, 1'b1);
        check("idle_dv_cnt", dv_cnt, 0);
        check("idle_fe_cnt", fe_cnt, 0);

        for (int v = 0; v < 7; v++) begin
            send_bits(vecs[v].word, 0, 13);
            do_latch(1'b1, 1'b0, 1'b0, vecs[v].exp_sel, vecs[v].exp_seg, $sformatf("vec%0d", v));
        end

        do_latch(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, "relatch");

        blank_step(1'b0, "oe_low");
        blank_step(1'b1, "oe_high");

`ifdef HC595_RX_FRAME_CHK_EN
        send_bits(14'h00C1, 0, 12);
        do_latch(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, "short_frame");
        send_bits(14'h00C1, 0, 13);
        do_latch(1'b1, 1'b0, 1'b0, 6'h01, 8'hC0, "after_short");
`endif

        // Coincident edges: the latch sees the pre-shift word, the shifted bit starts the next frame.
        send_bits(14'h1260, 0, 13);
        do_latch(1'b1, 1'b1, 1'b0, 6'h20, 8'h92, "same_edge");
        send_bits(14'h27C2, 1, 13);
        do_latch(1'b1, 1'b0, 1'b0, 6'h02, 8'hF9, "post_same_edge");

        oe = 1'b0;
        repeat (6) @(negedge sys_clk);
        check("pre_rst_blank", blank, 1'b0);
        send_bits(14'h3FFF, 0, 6);
        fe0 = fe_cnt;
        @(negedge sys_clk) sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("midrst_sel", sel, 6'h00);
        check("midrst_seg", seg, 8'h00);
        check("midrst_blank", blank, 1'b1);
        check("midrst_dv", data_valid, 1'b0);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        send_bits(14'h27C2, 0, 13);
        do_latch(1'b1, 1'b0, 1'b0, 6'h02, 8'hF9, "after_rst");
        check("after_rst_fe_cnt", fe_cnt, fe0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
